// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; the master modport is the CPU + memory side.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the instruction-fetch and data ports.
// One access in flight at a time; arbitration only in IDLE and RESP.
module mem_port_arbiter #(
   parameter int MEM_LAT   = 1,
   parameter bit PRIO_MODE = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus,
   output logic               busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} port_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   port_t            owner, owner_nxt;
   port_t            last_owner, last_owner_nxt;
   logic             owner_we, owner_we_nxt;
   logic             capture;
   port_t            winner;
   logic [31:0]      if_rdata_q;
   logic [31:0]      d_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         owner      <= PORT_IF;
         last_owner <= PORT_D;
         owner_we   <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         owner_we   <= owner_we_nxt;
         // Stores complete without touching the load-data register.
         if (capture) begin
            if (owner == PORT_IF) begin
               if_rdata_q <= bus.mem_rdata;
            end else if (!owner_we) begin
               d_rdata_q <= bus.mem_rdata;
            end
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      owner_we_nxt   = owner_we;
      capture        = 1'b0;
      winner         = PORT_IF;
      bus.if_gnt     = 1'b0;
      bus.d_gnt      = 1'b0;
      bus.mem_en     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;

      // Round-robin hands a conflict to whichever port did not win last time.
      if (bus.if_req && bus.d_req) begin
         if (PRIO_MODE || (last_owner == PORT_IF)) begin
            winner = PORT_D;
         end
      end else if (bus.d_req) begin
         winner = PORT_D;
      end

      case (state)
         IDLE, RESP: begin
            if (bus.if_req || bus.d_req) begin
               state_nxt      = WAIT;
               cnt_nxt        = CNT_INIT;
               owner_nxt      = winner;
               last_owner_nxt = winner;
               bus.mem_en     = 1'b1;
               if (winner == PORT_D) begin
                  bus.d_gnt     = 1'b1;
                  bus.mem_we    = bus.d_we;
                  bus.mem_addr  = bus.d_addr;
                  bus.mem_wdata = bus.d_wdata;
                  owner_we_nxt  = bus.d_we;
               end else begin
                  bus.if_gnt    = 1'b1;
                  bus.mem_addr  = bus.if_addr;
                  owner_we_nxt  = 1'b0;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (reset) begin
         bus.if_gnt = 1'b0;
         bus.d_gnt  = 1'b0;
         bus.mem_en = 1'b0;
         bus.mem_we = 1'b0;
      end
   end

   assign bus.if_rvalid = !reset && (state == RESP) && (owner == PORT_IF);
   assign bus.d_rvalid  = !reset && (state == RESP) && (owner == PORT_D);
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LAT1/RR, LAT1/data-prio, LAT3/RR) driven
// from a vector table, directed sequences and random traffic, all checked by a cycle-rule model.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
   } in_t;

   typedef struct packed {
      logic        if_gnt;
      logic        if_rvalid;
      logic [31:0] if_rdata;
      logic        d_gnt;
      logic        d_rvalid;
      logic [31:0] d_rdata;
      logic        mem_en;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        busy;
   } out_t;

   typedef struct {
      logic        rst;
      in_t         stim;
      logic [31:0] rd;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_rdata;
   in_t         drv [3];
   out_t        obs [3];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      mem_port_arbiter_if bus ();
      logic busy;
      assign bus.if_req    = drv[k].if_req;
      assign bus.if_addr   = drv[k].if_addr;
      assign bus.d_req     = drv[k].d_req;
      assign bus.d_we      = drv[k].d_we;
      assign bus.d_addr    = drv[k].d_addr;
      assign bus.d_wdata   = drv[k].d_wdata;
      assign bus.mem_rdata = mem_rdata;
      assign obs[k] = {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid,
                       bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy};
      mem_port_arbiter #(.MEM_LAT(k == 2 ? 3 : 1), .PRIO_MODE(k == 1 ? 1'b1 : 1'b0)) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus),
         .busy  (busy)
      );
   end

   // Reference model: tracks only the last grant (cycle, port, store flag) and derives
   // WAIT/RESP windows from cycle arithmetic against each instance's latency.
   int          cyc;
   int          gCyc   [3];
   bit          pend   [3];
   bit          gPortD [3];
   bit          gWe    [3];
   bit          lastD  [3];
   logic [31:0] ifRd   [3];
   logic [31:0] dRd    [3];
   bit          expIfG [3];
   bit          expDG  [3];

   task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d cyc%0d: got %h expected %h", name, k, cyc, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 3; k++) begin
         pend[k] = 1'b0; lastD[k] = 1'b1; ifRd[k] = '0; dRd[k] = '0;
         gCyc[k] = -100; expIfG[k] = 1'b0; expDG[k] = 1'b0;
      end
   endtask

   task automatic modelStep();
      for (int k = 0; k < 3; k++) begin
         int lat;
         bit prio, inWait, inResp, egI, egD, eIv, eDv;
         lat    = (k == 2) ? 3 : 1;
         prio   = (k == 1);
         inWait = pend[k] && (cyc > gCyc[k]) && (cyc <= gCyc[k] + lat);
         inResp = pend[k] && (cyc == gCyc[k] + lat + 1);
         egI = 1'b0; egD = 1'b0;
         if (!reset && !inWait) begin
            if (drv[k].if_req && drv[k].d_req) begin
               if (prio || !lastD[k]) egD = 1'b1; else egI = 1'b1;
            end else if (drv[k].d_req) egD = 1'b1;
            else if (drv[k].if_req) egI = 1'b1;
         end
         eIv = !reset && inResp && !gPortD[k];
         eDv = !reset && inResp && gPortD[k];
         checkOutput("if_gnt", k, 32'(obs[k].if_gnt), 32'(egI));
         checkOutput("d_gnt", k, 32'(obs[k].d_gnt), 32'(egD));
         checkOutput("mem_en", k, 32'(obs[k].mem_en), 32'(egI | egD));
         checkOutput("mem_we", k, 32'(obs[k].mem_we), 32'(egD & drv[k].d_we));
         checkOutput("if_rvalid", k, 32'(obs[k].if_rvalid), 32'(eIv));
         checkOutput("d_rvalid", k, 32'(obs[k].d_rvalid), 32'(eDv));
         checkOutput("if_rdata", k, obs[k].if_rdata, ifRd[k]);
         checkOutput("d_rdata", k, obs[k].d_rdata, dRd[k]);
         checkOutput("busy", k, 32'(obs[k].busy), 32'(inWait | inResp));
         if (egI) checkOutput("mem_addr", k, obs[k].mem_addr, drv[k].if_addr);
         if (egD) checkOutput("mem_addr", k, obs[k].mem_addr, drv[k].d_addr);
         if (egD && drv[k].d_we) checkOutput("mem_wdata", k, obs[k].mem_wdata, drv[k].d_wdata);
         expIfG[k] = egI;
         expDG[k]  = egD;
         if (reset) begin
            pend[k] = 1'b0; lastD[k] = 1'b1; ifRd[k] = '0; dRd[k] = '0;
         end else begin
            if (pend[k] && (cyc == gCyc[k] + lat)) begin
               if (!gPortD[k]) ifRd[k] = mem_rdata;
               else if (!gWe[k]) dRd[k] = mem_rdata;
            end
            if (egI || egD) begin
               pend[k] = 1'b1; gCyc[k] = cyc; gPortD[k] = egD;
               gWe[k] = egD && drv[k].d_we; lastD[k] = egD;
            end
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic applyStimulus(input logic r, input in_t v, input logic [31:0] rd);
      reset     = r;
      mem_rdata = rd;
      for (int k = 0; k < 3; k++) drv[k] = v;
   endtask

   // One cycle: drive, check every instance against the model at the falling edge, advance.
   task automatic runCycle(input logic r, input in_t v, input logic [31:0] rd);
      applyStimulus(r, v, rd);
      @(negedge clk);
      modelStep();
      advance();
   endtask

   function automatic in_t mkIn(bit ir, logic [31:0] ia, bit dr, bit we, logic [31:0] da,
                                logic [31:0] dw);
      in_t v;
      v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = we; v.d_addr = da; v.d_wdata = dw;
      return v;
   endfunction

   function automatic out_t mkOut(bit ig, bit iv, logic [31:0] ird, bit dg, bit dv,
                                  logic [31:0] drd, bit en, bit we, logic [31:0] ma,
                                  logic [31:0] mw, bit bsy);
      out_t o;
      o.if_gnt = ig; o.if_rvalid = iv; o.if_rdata = ird; o.d_gnt = dg; o.d_rvalid = dv;
      o.d_rdata = drd; o.mem_en = en; o.mem_we = we; o.mem_addr = ma; o.mem_wdata = mw;
      o.busy = bsy;
      return o;
   endfunction

   vec_t tbl [14];
   in_t  idleIn;

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) runCycle(1'b0, idleIn, 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      in_t v;
      int  ifCnt [3];
      int  dCnt  [3];
      int  dvCnt;
      logic [31:0] aI, aD;

      idleIn = mkIn(0, 0, 0, 0, 0, 0);
      applyStimulus(1'b1, idleIn, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      cyc = 0;

      // Fetch/store basics on LAT=1, then a held conflict that must alternate fetch/data.
      aI = 32'h2008000A;
      tbl[0]  = '{1, idleIn, 0, mkOut(0,0,0, 0,0,0, 0,0,0,0, 0)};
      tbl[1]  = '{0, mkIn(1,32'h00400000,0,0,0,0), 0, mkOut(1,0,0, 0,0,0, 1,0,32'h00400000,0, 0)};
      tbl[2]  = '{0, idleIn, aI, mkOut(0,0,0, 0,0,0, 0,0,0,0, 1)};
      tbl[3]  = '{0, mkIn(0,0,1,1,32'h10010004,32'hDEADBEEF), 0,
                  mkOut(0,1,aI, 1,0,0, 1,1,32'h10010004,32'hDEADBEEF, 1)};
      tbl[4]  = '{0, idleIn, 32'h12345678, mkOut(0,0,aI, 0,0,0, 0,0,0,0, 1)};
      tbl[5]  = '{0, idleIn, 0, mkOut(0,0,aI, 0,1,0, 0,0,0,0, 1)};
      tbl[6]  = '{0, mkIn(1,32'h00400004,1,0,32'h10010008,0), 0,
                  mkOut(1,0,aI, 0,0,0, 1,0,32'h00400004,0, 0)};
      tbl[7]  = '{0, mkIn(1,32'h00400008,1,0,32'h10010008,0), 32'hAAAA0001,
                  mkOut(0,0,aI, 0,0,0, 0,0,0,0, 1)};
      tbl[8]  = '{0, mkIn(1,32'h00400008,1,0,32'h10010008,0), 0,
                  mkOut(0,1,32'hAAAA0001, 1,0,0, 1,0,32'h10010008,0, 1)};
      tbl[9]  = '{0, mkIn(1,32'h00400008,1,0,32'h1001000C,0), 32'hBBBB0002,
                  mkOut(0,0,32'hAAAA0001, 0,0,0, 0,0,0,0, 1)};
      tbl[10] = '{0, mkIn(1,32'h00400008,1,0,32'h1001000C,0), 0,
                  mkOut(1,0,32'hAAAA0001, 0,1,32'hBBBB0002, 1,0,32'h00400008,0, 1)};
      tbl[11] = '{0, idleIn, 32'hCCCC0003, mkOut(0,0,32'hAAAA0001, 0,0,32'hBBBB0002, 0,0,0,0, 1)};
      tbl[12] = '{0, idleIn, 0, mkOut(0,1,32'hCCCC0003, 0,0,32'hBBBB0002, 0,0,0,0, 1)};
      tbl[13] = '{0, idleIn, 0, mkOut(0,0,32'hCCCC0003, 0,0,32'hBBBB0002, 0,0,0,0, 0)};

      for (int i = 0; i < 14; i++) begin
         applyStimulus(tbl[i].rst, tbl[i].stim, tbl[i].rd);
         @(negedge clk);
         modelStep();
         checkOutput("tbl.if_gnt", 0, 32'(obs[0].if_gnt), 32'(tbl[i].exp.if_gnt));
         checkOutput("tbl.d_gnt", 0, 32'(obs[0].d_gnt), 32'(tbl[i].exp.d_gnt));
         checkOutput("tbl.mem_en", 0, 32'(obs[0].mem_en), 32'(tbl[i].exp.mem_en));
         checkOutput("tbl.mem_we", 0, 32'(obs[0].mem_we), 32'(tbl[i].exp.mem_we));
         checkOutput("tbl.if_rvalid", 0, 32'(obs[0].if_rvalid), 32'(tbl[i].exp.if_rvalid));
         checkOutput("tbl.d_rvalid", 0, 32'(obs[0].d_rvalid), 32'(tbl[i].exp.d_rvalid));
         checkOutput("tbl.if_rdata", 0, obs[0].if_rdata, tbl[i].exp.if_rdata);
         checkOutput("tbl.d_rdata", 0, obs[0].d_rdata, tbl[i].exp.d_rdata);
         checkOutput("tbl.busy", 0, 32'(obs[0].busy), 32'(tbl[i].exp.busy));
         if (tbl[i].exp.mem_en) checkOutput("tbl.mem_addr", 0, obs[0].mem_addr, tbl[i].exp.mem_addr);
         if (tbl[i].exp.mem_we) checkOutput("tbl.mem_wdata", 0, obs[0].mem_wdata, tbl[i].exp.mem_wdata);
         advance();
      end

      // Both ports held: round-robin alternates, data-priority starves fetch.
      drain(6);
      for (int k = 0; k < 3; k++) begin ifCnt[k] = 0; dCnt[k] = 0; end
      v = mkIn(1, 32'h00400100, 1, 0, 32'h10010100, 0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, v, 32'h5000_0000 + 32'(i));
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            ifCnt[k] += int'(obs[k].if_gnt);
            dCnt[k]  += int'(obs[k].d_gnt);
         end
         modelStep();
         advance();
      end
      checkOutput("rr.if_gnt_count", 0, 32'(ifCnt[0]), 32'd3);
      checkOutput("rr.d_gnt_count", 0, 32'(dCnt[0]), 32'd3);
      checkOutput("prio.if_gnt_count", 1, 32'(ifCnt[1]), 32'd0);
      checkOutput("prio.d_gnt_count", 1, 32'(dCnt[1]), 32'd6);
      v.d_req = 1'b0;
      for (int i = 0; i < 6; i++) runCycle(1'b0, v, 32'h6000_0000 + 32'(i));

      // MEM_LAT=3: fetch at T0, data request waits through WAIT and is granted in RESP.
      drain(6);
      runCycle(1'b0, mkIn(1, 32'h00400200, 0, 0, 0, 0), 32'h0);
      v = mkIn(0, 0, 1, 0, 32'h10010200, 0);
      for (int t = 1; t <= 4; t++) begin
         applyStimulus(1'b0, v, 32'h7000_0000 + 32'(t));
         @(negedge clk);
         if (t < 4) begin
            checkOutput("lat3.busy", 2, 32'(obs[2].busy), 32'd1);
            checkOutput("lat3.no_gnt", 2, 32'(obs[2].if_gnt | obs[2].d_gnt), 32'd0);
         end else begin
            checkOutput("lat3.if_rvalid", 2, 32'(obs[2].if_rvalid), 32'd1);
            checkOutput("lat3.if_rdata", 2, obs[2].if_rdata, 32'h7000_0003);
            checkOutput("lat3.d_gnt", 2, 32'(obs[2].d_gnt), 32'd1);
         end
         modelStep();
         advance();
      end
      drain(6);

      // Reset during WAIT of a load abandons it silently.
      runCycle(1'b0, mkIn(0, 0, 1, 0, 32'h10010300, 0), 32'h0);
      runCycle(1'b1, idleIn, 32'h8888_8888);
      dvCnt = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, idleIn, 32'h9999_9999);
         @(negedge clk);
         if (i == 0) checkOutput("rst.all_zero_busy", 2, 32'(obs[2].busy), 32'd0);
         if (i == 0) checkOutput("rst.all_zero_rdata", 2, obs[2].d_rdata | obs[2].if_rdata, 32'd0);
         dvCnt += int'(obs[2].d_rvalid);
         modelStep();
         advance();
      end
      checkOutput("rst.no_d_rvalid", 2, 32'(dvCnt), 32'd0);
      applyStimulus(1'b0, mkIn(0, 0, 1, 0, 32'h10010304, 0), 32'h0);
      @(negedge clk);
      checkOutput("rst.regrant", 2, 32'(obs[2].d_gnt), 32'd1);
      modelStep();
      advance();
      drain(6);

      // Random traffic per instance; each requester holds until its predicted grant.
      for (int i = 0; i < 900; i++) begin
         logic r;
         r = ($urandom_range(0, 149) == 0);
         reset     = r;
         mem_rdata = $urandom;
         for (int k = 0; k < 3; k++) begin
            if (!drv[k].if_req || expIfG[k]) begin
               drv[k].if_req  = ($urandom_range(0, 9) < 4);
               drv[k].if_addr = $urandom;
            end
            if (!drv[k].d_req || expDG[k]) begin
               drv[k].d_req   = ($urandom_range(0, 9) < 4);
               drv[k].d_we    = $urandom_range(0, 1) == 1;
               drv[k].d_addr  = $urandom;
               drv[k].d_wdata = $urandom;
            end
         end
         @(negedge clk);
         modelStep();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
